// File: rtl/common_pkg.sv
// Shared types for the execute stage: ALU opcodes and the divider FSM state.
// Also small opcode classification helpers used by the divider.
package common_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  function automatic logic is_div_op(alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) ||
           (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(alu_op_t op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Execute-stage <-> divider bundle: request side from the decoder,
// result side back to write-back.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  import common_pkg::*;

  logic             start;
  alu_op_t          alu_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [4:0]       write_back_id;
  logic             flush;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [4:0]       result_id;

  modport master (
    output start,
    output alu_op,
    output operand_a,
    output operand_b,
    output write_back_id,
    output flush,
    input  stall,
    input  result_valid,
    input  result,
    input  result_id
  );

  modport slave (
    input  start,
    input  alu_op,
    input  operand_a,
    input  operand_b,
    input  write_back_id,
    input  flush,
    output stall,
    output result_valid,
    output result,
    output result_id
  );

endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit
// per cycle on magnitudes, with sign fixup folded into the final write.
module div_sequencer
  import common_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  div_sequencer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;
  logic             rem_sel;
  logic [4:0]       id_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       result_id_q;

  logic             op_ok;
  logic             sgn;
  logic             rem_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             ovf;
  logic             special;
  logic             accept;
  logic [WIDTH-1:0] special_res;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             last;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] final_res;

  assign op_ok    = is_div_op(bus.alu_op);
  assign sgn      = is_signed_op(bus.alu_op);
  assign rem_op   = is_rem_op(bus.alu_op);
  assign a_neg    = sgn & bus.operand_a[WIDTH-1];
  assign b_neg    = sgn & bus.operand_b[WIDTH-1];
  assign a_mag    = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag    = b_neg ? -bus.operand_b : bus.operand_b;
  assign div_zero = (bus.operand_b == '0);
  assign ovf      = sgn & (bus.operand_a == MIN_NEG)
                  & (&bus.operand_b);
  assign special  = div_zero | ovf;
  assign accept   = (state == IDLE) & bus.start & op_ok;

  // Results that bypass the iteration entirely
  always_comb begin
    special_res = '0;
    unique case (1'b1)
      div_zero & rem_op:  special_res = bus.operand_a;
      div_zero & ~rem_op: special_res = '1;
      ~div_zero & rem_op: special_res = '0;
      default:            special_res = bus.operand_a;
    endcase
  end

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign trial   = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
  assign fits    = ~trial[WIDTH];
  assign rem_nxt = fits ? trial[WIDTH-1:0]
                        : {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign quo_nxt = {quo[WIDTH-2:0], fits};
  assign last    = (cnt == CW'(WIDTH - 1));
  assign mag     = rem_sel ? rem_nxt : quo_nxt;
  assign final_res = (rem_sel ? neg_r : neg_q) ? -mag : mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = special ? DONE : BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_comb begin
    bus.stall        = accept | (state == BUSY);
    bus.result_valid = (state == DONE) & ~bus.flush;
    bus.result       = result_q;
    bus.result_id    = result_id_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      quo         <= '0;
      rem         <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      rem_sel     <= 1'b0;
      id_q        <= '0;
      result_q    <= '0;
      result_id_q <= '0;
    end else begin
      if (accept) begin
        cnt     <= '0;
        quo     <= a_mag;
        rem     <= '0;
        dvsr    <= b_mag;
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        rem_sel <= rem_op;
        id_q    <= bus.write_back_id;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        quo <= quo_nxt;
        rem <= rem_nxt;
      end
      // A flushed operation never reaches the result registers
      if (!bus.flush) begin
        if (accept && special) begin
          result_q    <= special_res;
          result_id_q <= bus.write_back_id;
        end else if (state == BUSY && last) begin
          result_q    <= final_res;
          result_id_q <= id_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vector table, randomized
// operations against an arithmetic model, and flush/reset sequences.
module tb_div_sequencer;
  import common_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  div_sequencer_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] model(alu_op_t op, logic [31:0] a,
                                        logic [31:0] b);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) return (op == ALU_DIV || op == ALU_DIVU) ? 32'hFFFF_FFFF : a;
    case (op)
      ALU_DIV:  r = sa / sb;
      ALU_REM:  r = sa % sb;
      ALU_DIVU: r = longint'(a) / longint'(b);
      default:  r = longint'(a) % longint'(b);
    endcase
    return r[31:0];
  endfunction

  function automatic bit is_special(alu_op_t op, logic [31:0] a,
                                    logic [31:0] b);
    return (b == 0) || ((op == ALU_DIV || op == ALU_REM) &&
           a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic run_op(input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] id,
                        input logic [31:0] exp, input bit special,
                        input bit poke, input string nm);
    int lat;
    bit got;
    bit busy_ok;
    logic [31:0] held;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.alu_op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.write_back_id = id;
    @(negedge clk);
    check({nm, ":stall_start"}, 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.start = poke;
    bus.alu_op = poke ? ALU_REMU : op;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.write_back_id = 5'(~id);
    lat = 0;
    got = 0;
    busy_ok = 1;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 5) bus.start = 1'b0;
      if (bus.result_valid) got = 1;
      else if (bus.stall !== 1'b1) busy_ok = 0;
    end
    bus.start = 1'b0;
    check({nm, ":got_valid"}, 64'(got), 64'd1);
    check({nm, ":latency"}, 64'(lat), special ? 64'd1 : 64'(W + 1));
    check({nm, ":result"}, 64'(bus.result), 64'(exp));
    check({nm, ":result_id"}, 64'(bus.result_id), 64'(id));
    check({nm, ":stall_busy"}, 64'(busy_ok), 64'd1);
    check({nm, ":stall_done"}, 64'(bus.stall), 64'd0);
    held = bus.result;
    @(negedge clk);
    check({nm, ":pulse_one"}, 64'(bus.result_valid), 64'd0);
    check({nm, ":hold"}, 64'(bus.result), 64'(held));
  endtask

  initial begin
    bit saw;
    alu_op_t op;
    logic [31:0] a;
    logic [31:0] b;
    int r;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.alu_op = ALU_ADD;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.write_back_id = '0;
    bus.flush = 1'b0;

    vecs.push_back('{ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0});
    vecs.push_back('{ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{ALU_REMU, 32'd5, 32'd0, 32'd5, 1'b1});
    vecs.push_back('{ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h8000_0000, 1'b1});
    vecs.push_back('{ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1});
    vecs.push_back('{ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0});
    vecs.push_back('{ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0});
    vecs.push_back('{ALU_REMU, 32'd0, 32'd3, 32'd0, 1'b0});
    vecs.push_back('{ALU_REM, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 1'b1});
    vecs.push_back('{ALU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0});

    repeat (2) @(negedge clk);
    check("reset:stall", 64'(bus.stall), 64'd0);
    check("reset:valid", 64'(bus.result_valid), 64'd0);
    check("reset:result", 64'(bus.result), 64'd0);
    check("reset:result_id", 64'(bus.result_id), 64'd0);
    reset = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
             vecs[i].exp, vecs[i].special, 1'b0, $sformatf("vec%0d", i));

    // Start pulses and operand changes while busy must be ignored
    run_op(ALU_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 1'b1, "poke");

    for (int i = 0; i < 40; i++) begin
      op = alu_op_t'(4'(int'(ALU_DIV) + int'($urandom_range(0, 3))));
      r = int'($urandom_range(0, 9));
      a = (r == 9) ? 32'h8000_0000 : $urandom;
      case (r)
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3, 4: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 5'($urandom), model(op, a, b),
             is_special(op, a, b), 1'b0, $sformatf("rnd%0d", i));
    end

    // Flush in cycle N+10 of a busy DIVU
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.alu_op = ALU_DIVU;
    bus.operand_a = 32'd1000;
    bus.operand_b = 32'd3;
    bus.write_back_id = 5'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    saw = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (bus.result_valid) saw = 1;
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush:stall_before", 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush:stall_after", 64'(bus.stall), 64'd0);
    check("flush:valid_after", 64'(bus.result_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (bus.result_valid) saw = 1;
    end
    check("flush:no_valid", 64'(saw), 64'd0);
    run_op(ALU_DIVU, 32'd1000, 32'd3, 5'd10, 32'd333, 1'b0, 1'b0,
           "post_flush");

    // Asynchronous reset in cycle N+5 of a busy DIV
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.alu_op = ALU_DIV;
    bus.operand_a = 32'd77;
    bus.operand_b = 32'd5;
    bus.write_back_id = 5'd21;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst:stall", 64'(bus.stall), 64'd0);
    check("arst:valid", 64'(bus.result_valid), 64'd0);
    check("arst:result", 64'(bus.result), 64'd0);
    check("arst:result_id", 64'(bus.result_id), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid || bus.stall) saw = 1;
    end
    check("arst:no_valid", 64'(saw), 64'd0);

    // A non-divide opcode never engages the sequencer
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.alu_op = ALU_ADD;
    bus.operand_a = 32'd9;
    bus.operand_b = 32'd3;
    @(negedge clk);
    check("alu_add:stall", 64'(bus.stall), 64'd0);
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.result_valid || bus.stall) saw = 1;
    end
    bus.start = 1'b0;
    check("alu_add:idle", 64'(saw), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division this cycle; sampled only in IDLE.
REQ-005 alu_op  input  alu_op_t  operation: ALU_DIV, ALU_DIVU, ALU_REM or ALU_REMU; any other value with start is ignored.
REQ-006 operand_a  input  WIDTH  dividend (rs1).
REQ-007 operand_b  input  WIDTH  divisor (rs2).
REQ-008 write_back_id  input  5  destination register tag, carried with the operation.
REQ-009 flush  input  1  abort any operation in progress.
REQ-010 stall  output  1  pipeline hold request.
REQ-011 result_valid  output  1  one-cycle pulse: result and result_id valid.
REQ-012 result  output  WIDTH  quotient or remainder.
REQ-013 result_id  output  5  write_back_id captured at start.

Function
REQ-014 FSM states are IDLE, BUSY and DONE.
REQ-015 Transition IDLE->BUSY on start with a valid op; capture |a|, |b|, the signs, the op and write_back_id.
REQ-016 Transition IDLE->DONE directly for the special cases in REQ-021 and REQ-022.
REQ-017 BUSY runs exactly WIDTH restoring shift-subtract iterations, one per cycle, counted by a log2(WIDTH)+1 bit counter; it moves to DONE after the last iteration.
REQ-018 DONE lasts one cycle with result_valid=1, then returns to IDLE.
REQ-019 Latency: start in cycle N gives result_valid in cycle N+WIDTH+1, or N+1 for special cases.
REQ-020 Signed ops negate the magnitude result: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 Divisor = 0 gives quotient all-ones (DIV and DIVU) and remainder = operand_a (REM and REMU).
REQ-022 DIV/REM with a = -2^(WIDTH-1) and b = -1 gives quotient -2^(WIDTH-1) and remainder 0.
REQ-023 stall = (IDLE & start & valid op) | BUSY, computed combinationally; stall = 0 in DONE so the pipeline advances with the result.
REQ-024 start is ignored outside IDLE.
REQ-025 flush forces IDLE on the next edge from any state, with result_valid=0 that cycle and no result issued; flush has priority over start in the same cycle.
REQ-026 Once captured, the operands are held internally; input changes during BUSY have no effect.
REQ-027 result and result_id are registered and hold their value after the DONE pulse until the next DONE.

Reset
REQ-028 reset forces IDLE; result_valid=0, stall=0, result=0, result_id=0, and clears the counter and working registers.
REQ-029 Reset asserted during BUSY discards the operation; no result_valid follows deassertion.

Structure
REQ-030 div_state_t (IDLE/BUSY/DONE) is added to common_pkg; alu_op_t is reused from common_pkg unchanged.
REQ-031 The control decoder drives alu_op and write_back_id; the block is instantiated in the execute stage alongside the ALU.
REQ-032 No sub-module; sign fixup and the iteration datapath stay inline.

Verification
REQ-033 DIVU 100/7 with start held one cycle -> stall high for cycles N..N+32, result_valid at N+33, result=14.
REQ-034 REM -7 by 2 (0xFFFFFFF9, 2) -> result 0xFFFFFFFF (-1); DIV of the same operands -> 0xFFFFFFFD (-3).
REQ-035 DIV 5/0 -> result 0xFFFFFFFF at N+1; REMU 5/0 -> result 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1.
REQ-036 DIVU started, flush pulsed at cycle N+10 -> IDLE at N+11, stall low, no result_valid; a new start at N+12 completes normally.
REQ-037 Async reset at cycle N+5 of BUSY -> outputs zero immediately, no result_valid after release; start with alu_op=ALU_ADD -> stall stays 0.
